// File: rtl/synapse_current_accum.sv
// Presynaptic current accumulator: once per timestep, decays the synaptic current,
// then serially adds signed weights of spiking inputs, saturating to [0, CUR_MAX].
//
// state   | meaning
// IDLE    | waiting for step_start; latches spike_in on accept
// DECAY   | acc <= acc - (acc >> DECAY_SHIFT), idx cleared
// SCAN    | one input per cycle, idx 0..N_INPUTS-1, adds weight when spiking
// DONE    | publishes acc to current_out; strobe follows next cycle
module synapse_current_accum #(
  parameter int          N_INPUTS    = 16,
  parameter int          WEIGHT_W    = 8,
  parameter logic [15:0] CUR_MAX     = 16'd1000,
  parameter int          DECAY_SHIFT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        step_start,
  input  logic [N_INPUTS-1:0]         spike_in,
  input  logic                        w_we,
  input  logic [$clog2(N_INPUTS)-1:0] w_addr,
  input  logic [WEIGHT_W-1:0]         w_data,
  output logic [15:0]                 current_out,
  output logic                        current_valid,
  output logic                        busy
);

  localparam int IDX_W = $clog2(N_INPUTS);
  localparam int SUM_W = (WEIGHT_W + 2 > 18) ? WEIGHT_W + 2 : 18;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DECAY, S_SCAN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [15:0]         acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_INPUTS-1:0] spk_q, spk_d;
  logic [15:0]         cur_q, cur_d;
  logic                valid_q, valid_d;
  logic [WEIGHT_W-1:0] weight_q [N_INPUTS];
  logic [WEIGHT_W-1:0] weight_d [N_INPUTS];

  logic [WEIGHT_W-1:0]    w_sel;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] max_s;
  logic [15:0]            sat_sum;

  // Wide signed sum so a negative weight on a small acc, or a large weight near
  // the ceiling, never wraps before the clamp.
  always_comb begin
    w_sel   = weight_q[idx_q];
    sum_s   = $signed({{(SUM_W-16){1'b0}}, acc_q})
            + $signed({{(SUM_W-WEIGHT_W){w_sel[WEIGHT_W-1]}}, w_sel});
    max_s   = $signed({{(SUM_W-16){1'b0}}, CUR_MAX});
    sat_sum = sum_s[15:0];
    if (sum_s < 0)
      sat_sum = '0;
    else if (sum_s > max_s)
      sat_sum = CUR_MAX;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    spk_d    = spk_q;
    cur_d    = cur_q;
    valid_d  = 1'b0;
    weight_d = weight_q;

    // The scan reads weight_q, so a write to the scanned index lands after the read.
    if (w_we && (int'(w_addr) < N_INPUTS))
      weight_d[w_addr] = w_data;

    case (state_q)
      S_IDLE: begin
        if (step_start) begin
          spk_d   = spike_in;
          state_d = S_DECAY;
        end
      end
      S_DECAY: begin
        acc_d   = acc_q - (acc_q >> DECAY_SHIFT);
        idx_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (spk_q[idx_q])
          acc_d = sat_sum;
        if (idx_q == IDX_LAST)
          state_d = S_DONE;
        else
          idx_d = idx_q + IDX_W'(1);
      end
      S_DONE: begin
        cur_d   = acc_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      spk_q    <= '0;
      cur_q    <= '0;
      valid_q  <= 1'b0;
      weight_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      spk_q    <= spk_d;
      cur_q    <= cur_d;
      valid_q  <= valid_d;
      weight_q <= weight_d;
    end
  end

  assign current_out   = cur_q;
  assign current_valid = valid_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_synapse_current_accum.sv
// Bench for synapse_current_accum: a behavioural model predicts each timestep's
// current, which is queued at step_start and checked when current_valid fires.
module tb_synapse_current_accum;

  logic        clk;
  logic        rst_n;
  logic        step_start;
  logic [15:0] spike_in;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic [15:0] current_out;
  logic        current_valid;
  logic        busy;

  synapse_current_accum dut (
    .clk(clk), .rst_n(rst_n), .step_start(step_start), .spike_in(spike_in),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .current_out(current_out), .current_valid(current_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int exp_q[$];
  int m_acc;
  int m_w[16];
  bit sat_viol;

  function automatic int model_step(input logic [15:0] spk);
    m_acc = m_acc - m_acc / 4;
    for (int i = 0; i < 16; i++) begin
      if (spk[i]) begin
        m_acc = m_acc + m_w[i];
        if (m_acc < 0) m_acc = 0;
        if (m_acc > 1000) m_acc = 1000;
      end
    end
    return m_acc;
  endfunction

  task automatic model_reset();
    m_acc = 0;
    for (int i = 0; i < 16; i++) m_w[i] = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    w_we   = 1'b1;
    w_addr = 4'(a);
    w_data = 8'(d);
    m_w[a] = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // Called at a negedge; the pulse is accepted at the following posedge.
  task automatic start_step(input logic [15:0] spk);
    step_start = 1'b1;
    spike_in   = spk;
    exp_q.push_back(model_step(spk));
  endtask

  // inj=1 pulses step_start and rewrites weight[7] in the cycle SCAN reads idx 7.
  task automatic wait_result(input string name, input int inj, input bit tail);
    int n;
    int e;
    @(negedge clk);
    step_start = 1'b0;
    n = 1;
    while (n < 40) begin
      if (current_out > 16'd1000) sat_viol = 1'b1;
      if (inj == 1 && n == 9) begin
        w_we = 1'b1; w_addr = 4'd7; w_data = 8'd90; step_start = 1'b1;
        m_w[7] = 90;
      end
      if (inj == 1 && n == 10) begin
        w_we = 1'b0; step_start = 1'b0;
      end
      if (current_valid) break;
      @(negedge clk);
      n++;
    end
    total++;
    if (current_valid && n == 19) passed++;
    else $display("FAIL %s latency: got %0d cycles (valid=%0b), required 19", name, n, current_valid);
    if (current_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s scoreboard: unexpected current_valid, current_out=%0d", name, current_out);
      end else begin
        e = exp_q.pop_front();
        if (current_out !== 16'(e))
          $display("FAIL %s current_out: got %0d, required %0d", name, current_out, e);
        else passed++;
      end
    end
    if (tail) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || current_valid !== 1'b0)
        $display("FAIL %s after strobe: busy=%0b valid=%0b, required 0 0", name, busy, current_valid);
      else passed++;
    end
  endtask

  task automatic test_reset();
    total++;
    if (current_out !== 16'd0 || current_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset: out=%0d valid=%0b busy=%0b, required 0 0 0", current_out, current_valid, busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (current_out !== 16'd0 || busy !== 1'b0)
      $display("FAIL post_reset: out=%0d busy=%0b, required 0 0", current_out, busy);
    else passed++;
  endtask

  task automatic test_basic();
    wr(0, 100);
    @(negedge clk);
    start_step(16'h0001);
    wait_result("basic", 0, 1'b1);
  endtask

  task automatic test_decay();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_step(16'h0000);
      wait_result("decay", 0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_step(16'h0001);
    wait_result("b2b_first", 0, 1'b0);
    start_step(16'h0003);
    wait_result("b2b_second", 0, 1'b1);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 16; i++) wr(i, 127);
    sat_viol = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start_step(16'hFFFF);
      wait_result("saturation", 0, 1'b1);
    end
    total++;
    if (sat_viol) $display("FAIL sat_bound: current_out exceeded 1000, required <= 1000");
    else passed++;
  endtask

  task automatic test_inhibition();
    do_reset();
    wr(0, 100);
    @(negedge clk);
    start_step(16'h0001);
    wait_result("inhib_setup", 0, 1'b1);
    wr(3, -128);
    wr(5, 50);
    @(negedge clk);
    start_step(16'h0028);
    wait_result("inhibition", 0, 1'b1);
  endtask

  task automatic test_collision();
    int extra;
    wr(7, 20);
    @(negedge clk);
    start_step(16'h0080);
    wait_result("collision", 1, 1'b1);
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (current_valid) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL single_valid: got %0d extra strobes, required 0", extra);
    else passed++;
    @(negedge clk);
    start_step(16'h0080);
    wait_result("new_weight", 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_step(16'h00FF);
    @(negedge clk);
    step_start = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL mid_busy: busy=%0b, required 1", busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || current_valid !== 1'b0 || current_out !== 16'd0)
      $display("FAIL mid_reset: busy=%0b valid=%0b out=%0d, required 0 0 0", busy, current_valid, current_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wr(0, 10);
    @(negedge clk);
    start_step(16'h0001);
    wait_result("after_reset", 0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; step_start = 1'b0; spike_in = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0; sat_viol = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_decay();
    test_back_to_back();
    test_saturation();
    test_inhibition();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
